pwm_meas_multi: RTL and testbench

Multi-channel, parametrised pulse-width measurement block for PWM-output sensors such as the TSL235R light-to-frequency converter. Each channel synchronises and deglitches its input and measures high and low segment widths in `ref_clk` cycles. Optionally, it averages widths over a power-of-two number of segments. It flags channels whose input has stopped toggling and publishes registered results with per-channel valid and update strobes for the AXI register front-end.

---
 rtl/pwm_meas_multi.sv | 185 ++++++++++++++++++
 tb/tb_pwm_meas_multi.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_meas_multi.sv
// Multi-channel PWM pulse-width meter: synchronise, deglitch, then time high/low segments
// per channel with optional power-of-two averaging, stuck-line detection and update strobes.
module pwm_meas_multi #(
    parameter int              NUM_CH      = 4,
    parameter int              CNT_W       = 32,
    parameter int              SYNC_STAGES = 2,
    parameter int              FILT_CYC    = 3,
    parameter int              AVG_LOG2    = 0,
    parameter longint unsigned TIMEOUT     = 64'd16777216
) (
    input  logic                    ref_clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic [NUM_CH-1:0]       pulse,
    output logic [NUM_CH*CNT_W-1:0] hi_time,
    output logic [NUM_CH*CNT_W-1:0] lo_time,
    output logic [NUM_CH-1:0]       valid,
    output logic [NUM_CH-1:0]       stuck,
    output logic [NUM_CH-1:0]       level,
    output logic [NUM_CH-1:0]       update
);

    typedef enum logic [1:0] {ST_IDLE, ST_PARTIAL, ST_MEASURE, ST_STUCK} ch_state_e;

    localparam int              ACC_W     = CNT_W + AVG_LOG2;
    localparam int              SC_W      = AVG_LOG2 + 1;
    localparam int              FC_W      = $clog2(FILT_CYC + 1);
    localparam logic [SC_W-1:0] SC_LAST   = SC_W'((1 << AVG_LOG2) - 1);
    localparam logic [63:0]     TIMEOUT_L = 64'(TIMEOUT);

    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic [FC_W-1:0]        fcnt_q;
        logic                   filt_q, level_q, prev_q;
        ch_state_e              state_q, state_d;
        logic [CNT_W-1:0]       timer_q, hi_q, lo_q, avg_val;
        logic [ACC_W-1:0]       acc_hi_q, acc_lo_q, acc_sel, acc_sum;
        logic [SC_W-1:0]        cnt_hi_q, cnt_lo_q, cnt_sel;
        logic                   sat_hi_q, sat_lo_q, pub_hi_q, pub_lo_q;
        logic                   valid_q, stuck_q, update_q;
        logic                   sync_out, edge_det, timed_out, seg_hi, seg_sat, win_sat;
        logic                   last_sample, sample_en, enter_stuck;

        // level_q trails filt_q by one cycle so the reported level lands SYNC_STAGES+FILT_CYC
        // cycles after the sampling edge; prev_q then marks the cycle after each level change.
        always_ff @(posedge ref_clk) begin
            if (reset) begin
                sync_q  <= '0;
                fcnt_q  <= '0;
                filt_q  <= 1'b0;
                level_q <= 1'b0;
                prev_q  <= 1'b0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], pulse[n]};
                if (sync_out != filt_q) begin
                    if (fcnt_q == FC_W'(FILT_CYC - 1)) begin
                        filt_q <= sync_out;
                        fcnt_q <= '0;
                    end else begin
                        fcnt_q <= fcnt_q + 1'b1;
                    end
                end else begin
                    fcnt_q <= '0;
                end
                level_q <= filt_q;
                prev_q  <= level_q;
            end
        end

        assign sync_out    = sync_q[SYNC_STAGES-1];
        assign edge_det    = level_q != prev_q;
        assign timed_out   = (TIMEOUT_L != 64'd0) && (64'(timer_q) >= TIMEOUT_L);
        assign seg_hi      = prev_q;
        assign seg_sat     = timer_q == '1;
        assign acc_sel     = seg_hi ? acc_hi_q : acc_lo_q;
        assign cnt_sel     = seg_hi ? cnt_hi_q : cnt_lo_q;
        assign acc_sum     = acc_sel + ACC_W'(timer_q);
        assign last_sample = cnt_sel == SC_LAST;
        assign win_sat     = seg_sat | (seg_hi ? sat_hi_q : sat_lo_q);
        assign avg_val     = win_sat ? '1 : CNT_W'(acc_sum >> AVG_LOG2);

        // An edge always wins over a timeout in the same cycle.
        always_comb begin
            state_d     = state_q;
            sample_en   = 1'b0;
            enter_stuck = 1'b0;
            if (edge_det) begin
                case (state_q)
                    ST_IDLE:    state_d = ST_PARTIAL;
                    ST_PARTIAL: state_d = ST_MEASURE;
                    ST_MEASURE: begin
                        state_d   = ST_MEASURE;
                        sample_en = 1'b1;
                    end
                    default:    state_d = ST_PARTIAL;
                endcase
            end else if (timed_out && (state_q == ST_PARTIAL || state_q == ST_MEASURE)) begin
                state_d     = ST_STUCK;
                enter_stuck = 1'b1;
            end
        end

        always_ff @(posedge ref_clk) begin
            if (reset || clear) begin
                state_q  <= ST_IDLE;
                timer_q  <= '0;
                acc_hi_q <= '0;
                acc_lo_q <= '0;
                cnt_hi_q <= '0;
                cnt_lo_q <= '0;
                sat_hi_q <= 1'b0;
                sat_lo_q <= 1'b0;
                pub_hi_q <= 1'b0;
                pub_lo_q <= 1'b0;
                hi_q     <= '0;
                lo_q     <= '0;
                valid_q  <= 1'b0;
                stuck_q  <= 1'b0;
                update_q <= 1'b0;
            end else begin
                state_q  <= state_d;
                update_q <= 1'b0;
                if (edge_det) begin
                    timer_q <= CNT_W'(1);
                    stuck_q <= 1'b0;
                end else if (!seg_sat) begin
                    timer_q <= timer_q + 1'b1;
                end
                if (sample_en && seg_hi) begin
                    if (last_sample) begin
                        hi_q     <= avg_val;
                        acc_hi_q <= '0;
                        cnt_hi_q <= '0;
                        sat_hi_q <= 1'b0;
                        pub_hi_q <= 1'b1;
                        valid_q  <= pub_lo_q;
                        update_q <= 1'b1;
                    end else begin
                        acc_hi_q <= acc_sum;
                        cnt_hi_q <= cnt_hi_q + 1'b1;
                        sat_hi_q <= win_sat;
                    end
                end
                if (sample_en && !seg_hi) begin
                    if (last_sample) begin
                        lo_q     <= avg_val;
                        acc_lo_q <= '0;
                        cnt_lo_q <= '0;
                        sat_lo_q <= 1'b0;
                        pub_lo_q <= 1'b1;
                        valid_q  <= pub_hi_q;
                        update_q <= 1'b1;
                    end else begin
                        acc_lo_q <= acc_sum;
                        cnt_lo_q <= cnt_lo_q + 1'b1;
                        sat_lo_q <= win_sat;
                    end
                end
                if (enter_stuck) begin
                    acc_hi_q <= '0;
                    acc_lo_q <= '0;
                    cnt_hi_q <= '0;
                    cnt_lo_q <= '0;
                    sat_hi_q <= 1'b0;
                    sat_lo_q <= 1'b0;
                    pub_hi_q <= 1'b0;
                    pub_lo_q <= 1'b0;
                    valid_q  <= 1'b0;
                    stuck_q  <= 1'b1;
                    update_q <= 1'b1;
                    hi_q     <= level_q ? '1 : '0;
                    lo_q     <= level_q ? '0 : '1;
                end
            end
        end

        assign hi_time[n*CNT_W +: CNT_W] = hi_q;
        assign lo_time[n*CNT_W +: CNT_W] = lo_q;
        assign valid[n]  = valid_q;
        assign stuck[n]  = stuck_q;
        assign level[n]  = level_q;
        assign update[n] = update_q;
    end

endmodule

// File: tb/tb_pwm_meas_multi.sv
// Bench for pwm_meas_multi: three instances (plain, 4-segment averaging, 8-bit no-timeout)
// exercised by a vector table, hand sequences and random segment streams vs a segment model.
module tb_pwm_meas_multi;

    logic        ref_clk = 1'b0;
    logic        reset   = 1'b1;
    logic        clear   = 1'b0;
    logic [1:0]  pulse_a = '0, pulse_b = '0, pulse_c = '0;
    logic [31:0] hi_a, lo_a, hi_b, lo_b;
    logic [15:0] hi_c, lo_c;
    logic [1:0]  valid_a, stuck_a, level_a, update_a;
    logic [1:0]  valid_b, stuck_b, level_b, update_b;
    logic [1:0]  valid_c, stuck_c, level_c, update_c;

    always #5 ref_clk = ~ref_clk;

    pwm_meas_multi #(.NUM_CH(2), .CNT_W(16), .SYNC_STAGES(2), .FILT_CYC(3), .AVG_LOG2(0),
                     .TIMEOUT(1000)) dut_a (
        .ref_clk(ref_clk), .reset(reset), .clear(clear), .pulse(pulse_a),
        .hi_time(hi_a), .lo_time(lo_a), .valid(valid_a), .stuck(stuck_a),
        .level(level_a), .update(update_a));

    pwm_meas_multi #(.NUM_CH(2), .CNT_W(16), .SYNC_STAGES(2), .FILT_CYC(3), .AVG_LOG2(2),
                     .TIMEOUT(1000)) dut_b (
        .ref_clk(ref_clk), .reset(reset), .clear(clear), .pulse(pulse_b),
        .hi_time(hi_b), .lo_time(lo_b), .valid(valid_b), .stuck(stuck_b),
        .level(level_b), .update(update_b));

    pwm_meas_multi #(.NUM_CH(2), .CNT_W(8), .SYNC_STAGES(2), .FILT_CYC(3), .AVG_LOG2(0),
                     .TIMEOUT(0)) dut_c (
        .ref_clk(ref_clk), .reset(reset), .clear(clear), .pulse(pulse_c),
        .hi_time(hi_c), .lo_time(lo_c), .valid(valid_c), .stuck(stuck_c),
        .level(level_c), .update(update_c));

    logic [15:0] hi_o [3][2];
    logic [15:0] lo_o [3][2];
    logic        vld_o [3][2];
    logic        stk_o [3][2];
    logic        lvl_o [3][2];
    logic        upd_o [3][2];

    always_comb begin
        for (int c = 0; c < 2; c++) begin
            hi_o[0][c] = hi_a[c*16 +: 16];
            lo_o[0][c] = lo_a[c*16 +: 16];
            hi_o[1][c] = hi_b[c*16 +: 16];
            lo_o[1][c] = lo_b[c*16 +: 16];
            hi_o[2][c] = {8'h00, hi_c[c*8 +: 8]};
            lo_o[2][c] = {8'h00, lo_c[c*8 +: 8]};
            vld_o[0][c] = valid_a[c];  vld_o[1][c] = valid_b[c];  vld_o[2][c] = valid_c[c];
            stk_o[0][c] = stuck_a[c];  stk_o[1][c] = stuck_b[c];  stk_o[2][c] = stuck_c[c];
            lvl_o[0][c] = level_a[c];  lvl_o[1][c] = level_b[c];  lvl_o[2][c] = level_c[c];
            upd_o[0][c] = update_a[c]; upd_o[1][c] = update_b[c]; upd_o[2][c] = update_c[c];
        end
    end

    int          checks = 0;
    int          errors = 0;
    logic [32:0] exp_q[$];
    bit          mon_en = 1'b0;
    int          mon_d  = 0;
    int          mon_ch = 0;
    int          upd_cnt [3][2];
    int          seg_q[$];

    typedef struct {
        int hi_w;
        int lo_w;
        int periods;
        int exp_hi;
        int exp_lo;
        int exp_upd;
        bit exp_valid;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: outputs are sampled 1ns after the rising edge; publish strobes feed the scoreboard.
    task automatic tick();
        logic [32:0] e;
        @(posedge ref_clk);
        #1;
        for (int d = 0; d < 3; d++)
            for (int c = 0; c < 2; c++)
                if (upd_o[d][c]) upd_cnt[d][c]++;
        if (mon_en && upd_o[mon_d][mon_ch]) begin
            if (exp_q.size() == 0) begin
                check("sb_extra_update", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("sb_publish", {31'd0, vld_o[mon_d][mon_ch], hi_o[mon_d][mon_ch],
                                     lo_o[mon_d][mon_ch]}, {31'd0, e});
            end
        end
    endtask

    task automatic set_pulse(input int d, input int ch, input bit v);
        case (d)
            0:       pulse_a[ch] = v;
            1:       pulse_b[ch] = v;
            default: pulse_c[ch] = v;
        endcase
    endtask

    task automatic hold(input int d, input int ch, input bit v, input int w);
        set_pulse(d, ch, v);
        repeat (w) tick();
    endtask

    task automatic do_reset();
        pulse_a = '0;
        pulse_b = '0;
        pulse_c = '0;
        clear   = 1'b0;
        reset   = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        repeat (2) tick();
    endtask

    // Segment model: segment j starts at filtered edge j+1 and ends at edge j+2. Edge 1 leaves
    // idle, edge 2 discards segment 0, later edges report. Widths clip to the counter maximum,
    // any clipped sample makes its window all-ones, windows of 2^alog samples are averaged.
    task automatic run_segs(input int d, input int ch, input bit first_lvl);
        int alog, maxv, n, w, lv;
        int sum [2];
        int cnt [2];
        bit sat [2];
        bit pub [2];
        int cur [2];
        alog = (d == 1) ? 2 : 0;
        maxv = (d == 2) ? 255 : 65535;
        n    = seg_q.size();
        for (int k = 0; k < 2; k++) begin
            sum[k] = 0; cnt[k] = 0; sat[k] = 1'b0; pub[k] = 1'b0; cur[k] = 0;
        end
        exp_q.delete();
        for (int j = 1; j <= n - 2; j++) begin
            lv = (j % 2 == 1) ? int'(!first_lvl) : int'(first_lvl);
            w  = seg_q[j];
            sum[lv] += (w > maxv) ? maxv : w;
            if (w >= maxv) sat[lv] = 1'b1;
            cnt[lv]++;
            if (cnt[lv] == (1 << alog)) begin
                cur[lv] = sat[lv] ? maxv : (sum[lv] >> alog);
                sum[lv] = 0;
                cnt[lv] = 0;
                sat[lv] = 1'b0;
                pub[lv] = 1'b1;
                exp_q.push_back({pub[0] & pub[1], cur[1][15:0], cur[0][15:0]});
            end
        end
        mon_d  = d;
        mon_ch = ch;
        mon_en = 1'b1;
        for (int j = 0; j < n; j++)
            hold(d, ch, (j % 2 == 1) ? !first_lvl : first_lvl, seg_q[j]);
        repeat (10) tick();
        mon_en = 1'b0;
        check("sb_drain", 64'(exp_q.size()), 64'd0);
        check("final_hi", 64'(hi_o[d][ch]), 64'(cur[1]));
        check("final_lo", 64'(lo_o[d][ch]), 64'(cur[0]));
        check("final_valid", 64'(vld_o[d][ch]), 64'(pub[0] & pub[1]));
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [6];
        int   u0, u1;
        bit   seen;

        vecs[0] = '{10, 30, 3, 10, 30, 4, 1'b1};
        vecs[1] = '{3, 3, 4, 3, 3, 6, 1'b1};
        vecs[2] = '{5, 100, 2, 5, 100, 2, 1'b1};
        vecs[3] = '{50, 7, 3, 50, 7, 4, 1'b1};
        vecs[4] = '{900, 3, 2, 900, 3, 2, 1'b1};
        vecs[5] = '{20, 20, 1, 0, 0, 0, 1'b0};

        for (int d = 0; d < 3; d++)
            for (int c = 0; c < 2; c++) upd_cnt[d][c] = 0;

        // reset state
        repeat (2) tick();
        for (int d = 0; d < 3; d++)
            for (int c = 0; c < 2; c++)
                check("reset_state", {28'd0, hi_o[d][c], lo_o[d][c], vld_o[d][c], stk_o[d][c],
                                      lvl_o[d][c], upd_o[d][c]}, 64'd0);
        reset = 1'b0;
        repeat (2) tick();

        // filtered level latency: SYNC_STAGES+FILT_CYC cycles after the sampling edge
        set_pulse(0, 0, 1'b1);
        repeat (5) tick();
        check("level_latency_early", 64'(lvl_o[0][0]), 64'd0);
        tick();
        check("level_latency", 64'(lvl_o[0][0]), 64'd1);

        // periodic patterns on dut_a channel 0
        for (int i = 0; i < 6; i++) begin
            do_reset();
            u0 = upd_cnt[0][0];
            u1 = upd_cnt[0][1];
            for (int p = 0; p < vecs[i].periods; p++) begin
                hold(0, 0, 1'b1, vecs[i].hi_w);
                hold(0, 0, 1'b0, vecs[i].lo_w);
            end
            repeat (8) tick();
            check("vec_hi", 64'(hi_o[0][0]), 64'(vecs[i].exp_hi));
            check("vec_lo", 64'(lo_o[0][0]), 64'(vecs[i].exp_lo));
            check("vec_valid", 64'(vld_o[0][0]), 64'(vecs[i].exp_valid));
            check("vec_updates", 64'(upd_cnt[0][0] - u0), 64'(vecs[i].exp_upd));
            check("vec_ch1_idle", {31'd0, hi_o[0][1], lo_o[0][1], vld_o[0][1]}, 64'd0);
            check("vec_ch1_updates", 64'(upd_cnt[0][1] - u1), 64'd0);
        end

        // glitch rejection, then a minimum-width pulse
        do_reset();
        u0   = upd_cnt[0][0];
        seen = 1'b0;
        set_pulse(0, 0, 1'b1);
        repeat (2) begin tick(); seen |= lvl_o[0][0]; end
        set_pulse(0, 0, 1'b0);
        repeat (30) begin tick(); seen |= lvl_o[0][0]; end
        check("glitch_level", 64'(seen), 64'd0);
        check("glitch_updates", 64'(upd_cnt[0][0] - u0), 64'd0);
        seg_q = '{10, 30, 10, 30, 3, 30, 20};
        run_segs(0, 0, 1'b1);
        check("min_pulse_hi", 64'(hi_o[0][0]), 64'd3);

        // averaging over 4 segments
        do_reset();
        u0    = upd_cnt[1][0];
        seg_q = '{5, 20, 10, 20, 11, 20, 12, 20, 14, 20, 20};
        run_segs(1, 0, 1'b1);
        check("avg_hi", 64'(hi_o[1][0]), 64'd11);
        check("avg_lo", 64'(lo_o[1][0]), 64'd20);
        check("avg_updates", 64'(upd_cnt[1][0] - u0), 64'd2);

        // saturation with timeout disabled
        do_reset();
        seg_q = '{300, 5, 300, 5, 300, 5, 20};
        run_segs(2, 0, 1'b1);
        check("sat_hi", 64'(hi_o[2][0]), 64'd255);
        check("sat_lo", 64'(lo_o[2][0]), 64'd5);
        check("sat_no_stuck", 64'(stk_o[2][0]), 64'd0);

        // stuck high on dut_a channel 1 and recovery
        do_reset();
        u1 = upd_cnt[0][1];
        hold(0, 1, 1'b1, 10);
        hold(0, 1, 1'b0, 10);
        hold(0, 1, 1'b1, 10);
        hold(0, 1, 1'b0, 10);
        hold(0, 1, 1'b1, 20);
        check("pre_stuck_valid", {62'd0, vld_o[0][1], stk_o[0][1]}, 64'd2);
        repeat (980) tick();
        check("stuck_early", 64'(stk_o[0][1]), 64'd0);
        repeat (15) tick();
        check("stuck_flags", {62'd0, stk_o[0][1], vld_o[0][1]}, 64'd2);
        check("stuck_hi", 64'(hi_o[0][1]), 64'hffff);
        check("stuck_lo", 64'(lo_o[0][1]), 64'd0);
        check("stuck_updates", 64'(upd_cnt[0][1] - u1), 64'd4);
        hold(0, 1, 1'b0, 10);
        check("stuck_cleared", 64'(stk_o[0][1]), 64'd0);
        hold(0, 1, 1'b1, 10);
        hold(0, 1, 1'b0, 10);
        check("recover_partial", {31'd0, vld_o[0][1], hi_o[0][1], lo_o[0][1]}, {31'd0, 1'b0, 16'd10, 16'd0});
        hold(0, 1, 1'b1, 20);
        check("recover_valid", {31'd0, vld_o[0][1], hi_o[0][1], lo_o[0][1]}, {31'd0, 1'b1, 16'd10, 16'd10});

        // clear mid-segment
        do_reset();
        for (int p = 0; p < 3; p++) begin
            hold(0, 0, 1'b1, 10);
            hold(0, 0, 1'b0, 30);
        end
        check("pre_clear_valid", 64'(vld_o[0][0]), 64'd1);
        clear = 1'b1;
        tick();
        check("clear_outputs", {28'd0, hi_o[0][0], lo_o[0][0], vld_o[0][0], stk_o[0][0],
                                upd_o[0][0]}, 64'd0);
        clear = 1'b0;
        hold(0, 0, 1'b0, 10);
        seg_q = '{10, 30, 10, 30, 10, 20};
        run_segs(0, 0, 1'b1);

        // reset mid-segment while clear is held
        hold(0, 0, 1'b1, 10);
        clear = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        check("reset_outputs", {27'd0, hi_o[0][0], lo_o[0][0], vld_o[0][0], stk_o[0][0],
                                lvl_o[0][0], upd_o[0][0]}, 64'd0);
        reset = 1'b0;
        clear = 1'b0;
        seg_q = '{20, 30, 10, 30, 10, 20};
        run_segs(0, 0, 1'b1);

        // random segment streams against the model
        do_reset();
        seg_q.delete();
        for (int j = 0; j < 24; j++) seg_q.push_back($urandom_range(3, 60));
        run_segs(0, 0, 1'b1);

        do_reset();
        seg_q.delete();
        for (int j = 0; j < 26; j++) seg_q.push_back($urandom_range(3, 60));
        run_segs(1, 0, 1'b1);

        do_reset();
        seg_q.delete();
        for (int j = 0; j < 20; j++) seg_q.push_back($urandom_range(3, 400));
        run_segs(2, 1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
